// File: rtl/aes_axil_reg_slave_if.sv
// AXI4-Lite bus bundle between an AXI master (PS, VIP or testbench) and aes_axil_reg_slave.
// Handshake rule for every channel: a beat transfers on a rising clock edge where VALID and READY are both 1.
interface aes_axil_reg_slave_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/aes_axil_reg_slave.sv
// AXI4-Lite register slave for the AES core: DATA words, CTRL start pulse, STATUS busy/done (W1C).
// Define AXIL_ADDR_CHECK_EN to answer out-of-range indices with SLVERR instead of aliasing.
module aes_axil_reg_slave #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 6
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  aes_axil_reg_slave_if.slave          s_axi,
  output logic [32*(NUM_REGS-2)-1:0]   reg_data_o,
  output logic                         start_o,
  input  logic                         busy_i,
  input  logic                         done_i
);
  localparam int LOW_W = $clog2(NUM_REGS);
  localparam int NDATA = NUM_REGS - 2;
  localparam logic [LOW_W-1:0] CTRL_IDX   = LOW_W'(NUM_REGS - 2);
  localparam logic [LOW_W-1:0] STATUS_IDX = LOW_W'(NUM_REGS - 1);
  localparam logic [LOW_W-1:0] NDATA_IDX  = LOW_W'(NDATA);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0]      data_q [NDATA];
  logic             aw_full_q, w_full_q, commit_q, bvalid_q, aw_err_q;
  logic [LOW_W-1:0] aw_idx_q;
  logic [31:0]      w_data_q;
  logic [3:0]       w_strb_q;
  logic [1:0]       bresp_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q;
  logic             start_q, done_q;

  logic             aw_ready, w_ready, ar_ready;
  logic             aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic             commit, wr_ok, ctrl_start, status_clr;
  logic             aw_err, ar_err;
  logic [LOW_W-1:0] ar_idx;
  logic [31:0]      rd_word;

`ifdef AXIL_ADDR_CHECK_EN
  logic [ADDR_W-3:0] aw_word, ar_word;
  assign aw_word = s_axi.S_AXI_AWADDR[ADDR_W-1:2];
  assign ar_word = s_axi.S_AXI_ARADDR[ADDR_W-1:2];
  assign aw_err  = |(aw_word >> LOW_W);
  assign ar_err  = |(ar_word >> LOW_W);
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  // READY outputs are forced low while reset is asserted, not just after the first edge.
  assign aw_ready = ~ARESET & ~aw_full_q & ~bvalid_q;
  assign w_ready  = ~ARESET & ~w_full_q & ~bvalid_q;
  assign ar_ready = ~ARESET & ~rvalid_q;

  assign aw_hs  = s_axi.S_AXI_AWVALID & aw_ready;
  assign w_hs   = s_axi.S_AXI_WVALID & w_ready;
  assign ar_hs  = s_axi.S_AXI_ARVALID & ar_ready;
  assign b_hs   = bvalid_q & s_axi.S_AXI_BREADY;
  assign r_hs   = rvalid_q & s_axi.S_AXI_RREADY;
  assign ar_idx = s_axi.S_AXI_ARADDR[LOW_W+1:2];

  assign commit     = aw_full_q & w_full_q & ~commit_q & ~bvalid_q;
  assign wr_ok      = commit & ~aw_err_q;
  assign ctrl_start = wr_ok & (aw_idx_q == CTRL_IDX) & w_strb_q[0] & w_data_q[0] & ~busy_i;
  assign status_clr = wr_ok & (aw_idx_q == STATUS_IDX) & w_strb_q[0] & w_data_q[1];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      commit_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_err_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= s_axi.S_AXI_AWADDR[LOW_W+1:2];
        aw_err_q  <= aw_err;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= s_axi.S_AXI_WDATA;
        w_strb_q <= s_axi.S_AXI_WSTRB;
      end
      // commit_q marks the cycle between the register update and BVALID rising.
      commit_q <= commit;
      if (commit) bresp_q <= aw_err_q ? RESP_SLVERR : RESP_OKAY;
      if (commit_q) bvalid_q <= 1'b1;
      if (b_hs) begin
        bvalid_q  <= 1'b0;
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
      end
      start_q <= ctrl_start;
      done_q  <= done_i | (done_q & ~status_clr);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int k = 0; k < NDATA; k++) data_q[k] <= '0;
    end else if (wr_ok && (aw_idx_q < NDATA_IDX)) begin
      for (int b = 0; b < 4; b++)
        if (w_strb_q[b]) data_q[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
    end
  end

  always_comb begin
    rd_word = '0;
    if (ar_idx < NDATA_IDX)        rd_word = data_q[ar_idx];
    else if (ar_idx == STATUS_IDX) rd_word = {30'b0, done_q, busy_i};
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= ar_err ? 32'h0 : rd_word;
      rresp_q  <= ar_err ? RESP_SLVERR : RESP_OKAY;
    end else if (r_hs) begin
      rvalid_q <= 1'b0;
    end
  end

  for (genvar k = 0; k < NDATA; k++) begin : g_data_out
    assign reg_data_o[32*k +: 32] = data_q[k];
  end

  assign s_axi.S_AXI_AWREADY = aw_ready;
  assign s_axi.S_AXI_WREADY  = w_ready;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = ar_ready;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign start_o             = start_q;
endmodule

// File: tb/tb_aes_axil_reg_slave.sv
// Self-checking bench for aes_axil_reg_slave: directed scenarios plus randomized traffic
// checked against a word-array reference model of the register map.
module tb_aes_axil_reg_slave;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 7;
  localparam int NDATA    = NUM_REGS - 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy = 1'b0;
  logic done = 1'b0;
  logic start;
  logic [32*NDATA-1:0] reg_data;

  aes_axil_reg_slave_if #(.ADDR_W(ADDR_W)) axi ();

  aes_axil_reg_slave #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .ACLK(clk), .ARESET(rst), .s_axi(axi), .reg_data_o(reg_data),
    .start_o(start), .busy_i(busy), .done_i(done)
  );

  always #5 clk = ~clk;

  // Scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  int start_seen = 0;
  int exp_start = 0;
  logic [31:0] mdl [NUM_REGS];
  logic mdl_done = 1'b0;
  logic [31:0] exp_q[$];

  always @(negedge clk) if (start) start_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: plain word array indexed by address/4.
  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) mdl[k] = 32'h0;
    mdl_done = 1'b0;
  endtask

  task automatic model_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    int idx;
    idx = int'(addr) / 4;
    resp = 2'b00;
`ifdef AXIL_ADDR_CHECK_EN
    if (idx >= NUM_REGS) begin
      resp = 2'b10;
      return;
    end
`else
    idx = idx % NUM_REGS;
`endif
    if (idx < NDATA) begin
      for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
    end else if (idx == NUM_REGS - 2) begin
      if (strb[0] && data[0] && !busy) exp_start++;
    end else if (strb[0] && data[1]) begin
      mdl_done = 1'b0;
    end
  endtask

  task automatic model_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
    int idx;
    idx = int'(addr) / 4;
    resp = 2'b00;
    data = 32'h0;
`ifdef AXIL_ADDR_CHECK_EN
    if (idx >= NUM_REGS) begin
      resp = 2'b10;
      return;
    end
`else
    idx = idx % NUM_REGS;
`endif
    if (idx < NDATA) data = mdl[idx];
    else if (idx == NUM_REGS - 1) data = {30'b0, mdl_done, busy};
  endtask

  // Drivers: inputs change on negedge, handshakes complete on the following posedge.
  task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_delay,
                           output logic [1:0] resp, output int lat);
    bit aw_done, w_done;
    int cyc, hs_cyc;
    aw_done = 0; w_done = 0; cyc = 0; hs_cyc = 0;
    @(negedge clk);
    axi.S_AXI_AWADDR  = addr;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA   = data;
    axi.S_AXI_WSTRB   = strb;
    axi.S_AXI_WVALID  = (w_delay == 0);
    while (!(aw_done && w_done) && cyc < 50) begin
      bit aw_f, w_f;
      aw_f = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_f  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(negedge clk);
      cyc++;
      if (aw_f) begin axi.S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_f)  begin axi.S_AXI_WVALID  = 1'b0; w_done  = 1; end
      if (!w_done && cyc >= w_delay) axi.S_AXI_WVALID = 1'b1;
      if (aw_done && w_done) hs_cyc = cyc;
    end
    check("wr_hs_bound", 32'(cyc < 50), 32'd1);
    while (!axi.S_AXI_BVALID && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("wr_bvalid_bound", 32'(axi.S_AXI_BVALID), 32'd1);
    lat = cyc - hs_cyc;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    resp = axi.S_AXI_BRESP;
    axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int cyc;
    cyc = 0;
    @(negedge clk);
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    while (axi.S_AXI_ARVALID && cyc < 50) begin
      bit f;
      f = axi.S_AXI_ARREADY;
      @(negedge clk);
      cyc++;
      if (f) axi.S_AXI_ARVALID = 1'b0;
    end
    while (!axi.S_AXI_RVALID && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rd_rvalid_bound", 32'(axi.S_AXI_RVALID), 32'd1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    data = axi.S_AXI_RDATA;
    resp = axi.S_AXI_RRESP;
    axi.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_RREADY = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    logic [1:0] exp_resp, resp;
    int lat;
    model_write(addr, data, strb, exp_resp);
    axi_write(addr, data, strb, $urandom_range(0, 3), resp, lat);
    check("bresp", 32'(resp), 32'(exp_resp));
    check("wr_latency", 32'(lat), 32'd2);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr);
    logic [31:0] exp_data, data;
    logic [1:0] exp_resp, resp;
    model_read(addr, exp_data, exp_resp);
    exp_q.push_back(exp_data);
    axi_read(addr, data, resp);
    check("rdata", data, exp_q.pop_front());
    check("rresp", 32'(resp), 32'(exp_resp));
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < NDATA; k++) check(tag, reg_data[32*k +: 32], mdl[k]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cnt;
    bit a_f, w_f, r_f;
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0;  axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARVALID = 1'b0; axi.S_AXI_RREADY = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(axi.S_AXI_AWREADY), 32'd0);
    check("rst_wready", 32'(axi.S_AXI_WREADY), 32'd0);
    check("rst_arready", 32'(axi.S_AXI_ARREADY), 32'd0);
    check("rst_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
    check("rst_rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
    check("rst_rdata", axi.S_AXI_RDATA, 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check_regs("rst_regs");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", 32'(axi.S_AXI_AWREADY), 32'd1);

    // Basic write/read-back
    for (int i = 0; i < 4; i++) do_write(ADDR_W'(4 * i), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) do_read(ADDR_W'(4 * i));
    check_regs("t1_regs");

    // Byte-strobe merge
    do_write(7'h00, 32'hAABBCCDD, 4'hF);
    do_write(7'h00, 32'h11223344, 4'b0101);
    do_read(7'h00);
    check("t3_merge_word0", reg_data[31:0], 32'hAA22CC44);

    // W three clocks ahead of AW, response stalled by BREADY
    begin
      logic [1:0] r2;
      model_write(7'h08, 32'h0BADF00D, 4'hF, r2);
    end
    @(negedge clk);
    axi.S_AXI_WDATA = 32'h0BADF00D; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
    w_f = axi.S_AXI_WREADY;
    @(negedge clk);
    check("t2_w_accept", 32'(w_f), 32'd1);
    axi.S_AXI_WVALID = 1'b0;
    check("t2_wready_latched", 32'(axi.S_AXI_WREADY), 32'd0);
    repeat (2) @(negedge clk);
    axi.S_AXI_AWADDR = 7'h08; axi.S_AXI_AWVALID = 1'b1;
    a_f = axi.S_AXI_AWREADY;
    @(negedge clk);
    check("t2_aw_accept", 32'(a_f), 32'd1);
    axi.S_AXI_AWVALID = 1'b0;
    cnt = 0;
    while (!axi.S_AXI_BVALID && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("t2_b_latency", 32'(cnt), 32'd2);
    repeat (5) begin
      @(negedge clk);
      check("t2_bvalid_held", 32'(axi.S_AXI_BVALID), 32'd1);
      check("t2_bresp_stable", 32'(axi.S_AXI_BRESP), 32'd0);
      check("t2_awready_blocked", 32'(axi.S_AXI_AWREADY), 32'd0);
      check("t2_wready_blocked", 32'(axi.S_AXI_WREADY), 32'd0);
    end
    axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_BREADY = 1'b0;
    check("t2_bvalid_clr", 32'(axi.S_AXI_BVALID), 32'd0);
    check("t2_awready_back", 32'(axi.S_AXI_AWREADY), 32'd1);
    do_read(7'h08);

    // CTRL start pulse, busy suppression, STATUS sticky done and W1C
    base = start_seen;
    do_write(7'h38, 32'h1, 4'hF);
    repeat (3) @(negedge clk);
    check("t4_start_pulse", 32'(start_seen - base), 32'd1);
    busy = 1'b1;
    base = start_seen;
    do_write(7'h38, 32'h1, 4'hF);
    repeat (3) @(negedge clk);
    check("t4_start_busy", 32'(start_seen - base), 32'd0);
    do_read(7'h3C);
    do_read(7'h38);
    busy = 1'b0;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    mdl_done = 1'b1;
    do_read(7'h3C);
    done = 1'b1;
    do_write(7'h3C, 32'h2, 4'hF);
    done = 1'b0;
    mdl_done = 1'b1;
    do_read(7'h3C);
    do_write(7'h3C, 32'h3, 4'hF);
    do_read(7'h3C);

    // Randomized traffic across the whole address space (in and out of range)
    for (int i = 0; i < 200; i++) begin
      busy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        do_write(ADDR_W'($urandom_range(0, 127)), $urandom, 4'($urandom_range(0, 15)));
      else
        do_read(ADDR_W'($urandom_range(0, 127)));
    end
    busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rand_start_count", 32'(start_seen), 32'(exp_start));
    check_regs("rand_regs");

    // Out-of-range index: SLVERR with address check, aliasing of word 0 without
    do_write(7'h00, 32'h12345678, 4'hF);
    do_write(7'h40, 32'h5555AAAA, 4'hF);
    do_read(7'h00);
    do_read(7'h40);
    check_regs("t6_regs");

    // Reset while both responses are pending
    @(negedge clk);
    axi.S_AXI_AWADDR = 7'h00; axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA = 32'hDEADBEEF; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
    axi.S_AXI_ARADDR = 7'h04; axi.S_AXI_ARVALID = 1'b1;
    cnt = 0;
    while (!(axi.S_AXI_BVALID && axi.S_AXI_RVALID) && cnt < 20) begin
      a_f = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_f = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      r_f = axi.S_AXI_ARVALID && axi.S_AXI_ARREADY;
      @(negedge clk);
      cnt++;
      if (a_f) axi.S_AXI_AWVALID = 1'b0;
      if (w_f) axi.S_AXI_WVALID = 1'b0;
      if (r_f) axi.S_AXI_ARVALID = 1'b0;
    end
    check("t5_both_valid", 32'(axi.S_AXI_BVALID && axi.S_AXI_RVALID), 32'd1);
    check("t5_word0_written", reg_data[31:0], 32'hDEADBEEF);
    #2 rst = 1'b1;
    #1;
    check("t5_bvalid_async", 32'(axi.S_AXI_BVALID), 32'd0);
    check("t5_rvalid_async", 32'(axi.S_AXI_RVALID), 32'd0);
    check("t5_awready_rst", 32'(axi.S_AXI_AWREADY), 32'd0);
    check("t5_arready_rst", 32'(axi.S_AXI_ARREADY), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_read(7'h00);
    do_read(7'h04);
    check_regs("t5_regs");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
